// File: rtl/rxpy_byte_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rxpy_byte_wr_pkg
// Purpose  : Shared definitions for the RX payload byte writer: FSM state
//            encoding, payload header lengths, default buffer limit and a
//            length clipping helper.
// Revision : 1.0 - initial release
// ============================================================================
package rxpy_byte_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_SKIP = 3'd3,
    ST_DONE = 3'd4
  } rxpy_state_e;

  localparam int HDR_BITS_BRSS    = 8;     // basic-rate single-slot header
  localparam int HDR_BITS_MS      = 16;    // all other payload headers
  localparam int MAXBYTES_DEFAULT = 1021;

  // Clip a byte length to the buffer limit.
  function automatic logic [9:0] clip_len(input logic [9:0] len,
                                          input logic [9:0] maxb);
    return (len > maxb) ? maxb : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rxpy_wr_hold.sv
`default_nettype none
// ============================================================================
// Module   : rxpy_wr_hold
// Purpose  : One-entry holding register in front of the RX payload buffer.
//            Presents a byte with mem_we until the buffer takes it
//            (mem_we & mem_ready) and advances the write address per transfer.
// Ports    : clk_6M, rstz       - clock, async active-low reset
//            clr                - packet (re)start: flush entry, address to 0
//            load, load_data    - new byte accepted into the entry
//            mem_ready          - buffer accepts the write this cycle
//            mem_we/addr/wdata  - buffer write request, address and data
// Revision : 1.0 - initial release
// ============================================================================
module rxpy_wr_hold #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              clr,
  input  logic              load,
  input  logic [7:0]        load_data,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata
);

  logic xfer;
  assign xfer = mem_we & mem_ready;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (clr) begin
      // An aborted packet must not leak a stale byte into the new one.
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end else begin
      // A load in the same cycle as a transfer refills the entry, so mem_we
      // stays high and the address already points at the next slot.
      if (load) begin
        mem_we    <= 1'b1;
        mem_wdata <= load_data;
      end else if (xfer) begin
        mem_we <= 1'b0;
      end
      if (xfer) begin
        mem_addr <= mem_addr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rxpy_byte_wr.sv
`default_nettype none
// ============================================================================
// Module   : rxpy_byte_wr
// Purpose  : Consumes the serial decoded payload bit stream, strips the
//            payload header, packs user data LSB-first into bytes and writes
//            them to the RX payload buffer. Reports byte count, CRC status,
//            overflow and truncation at end of packet.
// Ports    : clk_6M, rstz                 - clock, async active-low reset
//            dec_py_period, bit_valid,    - decode window and bit stream
//            bit_in
//            existpyheader, BRss,         - header presence / length select
//            dec_pylenByte, rxpybitlen    - payload length sources
//            crcencode, dec_crcgood       - CRC presence / upstream result
//            mem_ready, mem_we, mem_addr, - buffer write handshake
//            mem_wdata
//            rxpy_done_p, rxpy_bytecnt,   - end-of-packet status
//            rxpy_crcerr, rxpy_ovf, rxpy_trunc
// Revision : 1.0 - initial release
// ============================================================================
module rxpy_byte_wr
  import rxpy_byte_wr_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int MAXBYTES = MAXBYTES_DEFAULT
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              dec_py_period,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              existpyheader,
  input  logic              BRss,
  input  logic [9:0]        dec_pylenByte,
  input  logic [12:0]       rxpybitlen,
  input  logic              crcencode,
  input  logic              dec_crcgood,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              rxpy_done_p,
  output logic [9:0]        rxpy_bytecnt,
  output logic              rxpy_crcerr,
  output logic              rxpy_ovf,
  output logic              rxpy_trunc
);

  localparam logic [9:0] MAXB = 10'(MAXBYTES);

  rxpy_state_e state;
  logic        dec_d;
  logic [3:0]  bitcnt;     // header bit count, or bit-in-byte count in DATA
  logic [7:0]  shreg;
  logic [9:0]  rxcnt;      // bytes completed from the stream (drives target)
  logic [9:0]  bytecnt;    // bytes accepted for writing
  logic [9:0]  target;
  logic        crc_smp;

  logic        rise, fall, bv, hold_busy, byte_done, load;
  logic [3:0]  hdr_last;
  logic [7:0]  new_byte;
  logic [9:0]  hdr_len, nohdr_len;
  logic        unused_bits;

  assign rise      = dec_py_period & ~dec_d;
  assign fall      = ~dec_py_period & dec_d;
  assign bv        = bit_valid & dec_py_period;
  assign hdr_last  = BRss ? 4'(HDR_BITS_BRSS - 1) : 4'(HDR_BITS_MS - 1);
  assign new_byte  = {bit_in, shreg[7:1]};
  assign hold_busy = mem_we & ~mem_ready;
  assign byte_done = (state == ST_DATA) & bv & ~rise & (bitcnt[2:0] == 3'd7);
  assign load      = byte_done & ~hold_busy;
  assign hdr_len   = clip_len(dec_pylenByte, MAXB);
  // Headerless length is whole bytes only; the buffer limit still applies.
  assign nohdr_len = clip_len(rxpybitlen[12:3], MAXB);
  assign unused_bits = ^rxpybitlen[2:0];

  rxpy_wr_hold #(.ADDR_W(ADDR_W)) u_hold (
    .clk_6M    (clk_6M),
    .rstz      (rstz),
    .clr       (rise),
    .load      (load),
    .load_data (new_byte),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state        <= ST_IDLE;
      dec_d        <= 1'b0;
      bitcnt       <= '0;
      shreg        <= '0;
      rxcnt        <= '0;
      bytecnt      <= '0;
      target       <= '0;
      crc_smp      <= 1'b0;
      rxpy_done_p  <= 1'b0;
      rxpy_bytecnt <= '0;
      rxpy_crcerr  <= 1'b0;
      rxpy_ovf     <= 1'b0;
      rxpy_trunc   <= 1'b0;
    end else begin
      dec_d       <= dec_py_period;
      rxpy_done_p <= 1'b0;
      if (rise) begin
        // Packet start, or restart after a missed end (no done pulse then).
        bitcnt       <= '0;
        shreg        <= '0;
        rxcnt        <= '0;
        bytecnt      <= '0;
        rxpy_bytecnt <= '0;
        rxpy_crcerr  <= 1'b0;
        rxpy_ovf     <= 1'b0;
        if (existpyheader) begin
          state      <= ST_HDR;
          target     <= '0;
          rxpy_trunc <= 1'b0;
        end else begin
          state      <= (nohdr_len == '0) ? ST_SKIP : ST_DATA;
          target     <= nohdr_len;
          rxpy_trunc <= (rxpybitlen[12:3] > MAXB);
        end
      end else if (fall && state != ST_IDLE) begin
        // Any partial byte in shreg is simply abandoned.
        state   <= ST_DONE;
        crc_smp <= crcencode & ~dec_crcgood;
      end else begin
        case (state)
          ST_HDR: begin
            if (bv) begin
              if (bitcnt == hdr_last) begin
                bitcnt     <= '0;
                target     <= hdr_len;
                rxpy_trunc <= (dec_pylenByte > MAXB);
                state      <= (hdr_len == '0) ? ST_SKIP : ST_DATA;
              end else begin
                bitcnt <= bitcnt + 4'd1;
              end
            end
          end
          ST_DATA: begin
            if (bv) begin
              shreg  <= new_byte;
              bitcnt <= {1'b0, bitcnt[2:0] + 3'd1};
              if (bitcnt[2:0] == 3'd7) begin
                rxcnt <= rxcnt + 10'd1;
                // A byte that finds the entry still occupied is lost.
                if (hold_busy) rxpy_ovf <= 1'b1;
                else           bytecnt  <= bytecnt + 10'd1;
                if (rxcnt + 10'd1 == target) state <= ST_SKIP;
              end
            end
          end
          ST_DONE: begin
            if (!mem_we) begin
              rxpy_done_p  <= 1'b1;
              rxpy_bytecnt <= bytecnt;
              rxpy_crcerr  <= crc_smp;
              state        <= ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rxpy_byte_wr.sv
`default_nettype none
// ============================================================================
// Module   : tb_rxpy_byte_wr
// Purpose  : Self-checking bench for rxpy_byte_wr: table of packet vectors
//            plus hand sequences for overflow, drain-before-done and
//            asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rxpy_byte_wr;

  logic        clk_6M = 1'b0;
  logic        rstz, dec_py_period, bit_valid, bit_in, existpyheader, BRss;
  logic [9:0]  dec_pylenByte;
  logic [12:0] rxpybitlen;
  logic        crcencode, dec_crcgood, mem_ready;
  logic        mem_we, rxpy_done_p, rxpy_crcerr, rxpy_ovf, rxpy_trunc;
  logic [9:0]  mem_addr, rxpy_bytecnt;
  logic [7:0]  mem_wdata;

  always #5 clk_6M = ~clk_6M;

  rxpy_byte_wr dut (
    .clk_6M(clk_6M), .rstz(rstz), .dec_py_period(dec_py_period),
    .bit_valid(bit_valid), .bit_in(bit_in), .existpyheader(existpyheader),
    .BRss(BRss), .dec_pylenByte(dec_pylenByte), .rxpybitlen(rxpybitlen),
    .crcencode(crcencode), .dec_crcgood(dec_crcgood), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rxpy_done_p(rxpy_done_p), .rxpy_bytecnt(rxpy_bytecnt),
    .rxpy_crcerr(rxpy_crcerr), .rxpy_ovf(rxpy_ovf), .rxpy_trunc(rxpy_trunc)
  );

  typedef struct {
    bit       hdr;
    bit       brss;
    int       pylen;
    int       bitlen;
    int       nbits;     // bits sent after the header
    bit [7:0] seed;      // byte i of the stream = seed*(i+1)
    bit       ce;
    bit       cg;
    int       exp_cnt;
    bit       exp_trunc;
    bit       exp_crc;
  } vec_t;

  vec_t       vecs[7];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic [7:0] exp_q[$];
  logic [9:0] cap_cnt;
  logic       cap_crc, cap_ovf, cap_trunc;

  // Record every completed buffer transfer.
  always @(negedge clk_6M) begin
    if (mem_we && mem_ready) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_pkt(input bit hdr, input bit brss, input logic [9:0] len,
                           input logic [12:0] blen, input bit ce, input bit cg);
    @(posedge clk_6M); #1;
    existpyheader = hdr; BRss = brss; dec_pylenByte = len; rxpybitlen = blen;
    crcencode = ce; dec_crcgood = cg; dec_py_period = 1'b1;
    wa_q.delete(); wd_q.delete();
    repeat (2) @(posedge clk_6M);
    @(negedge clk_6M);
    check("start_clear", {rxpy_bytecnt, rxpy_ovf, rxpy_trunc, rxpy_crcerr}, 0);
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk_6M); #1;
    bit_valid = 1'b1; bit_in = b;
    @(posedge clk_6M); #1;
    bit_valid = 1'b0;
    @(posedge clk_6M);
  endtask

  task automatic end_pkt();
    @(posedge clk_6M); #1;
    dec_py_period = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_6M);
      if (rxpy_done_p) begin
        got = 1'b1;
        cap_cnt = rxpy_bytecnt; cap_crc = rxpy_crcerr;
        cap_ovf = rxpy_ovf;     cap_trunc = rxpy_trunc;
        break;
      end
    end
    check("done_seen", got, 1);
    if (got) begin
      @(negedge clk_6M);
      check("done_pulse_width", rxpy_done_p, 0);
    end
  endtask

  task automatic check_writes(input string nm);
    int mism = 0;
    int n;
    check({nm, "_nwrites"}, wa_q.size(), exp_q.size());
    n = (wa_q.size() < exp_q.size()) ? wa_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (wa_q[i] !== 10'(i) || wd_q[i] !== exp_q[i]) begin
        if (mism == 0)
          $display("write %0d: addr %0d data %0h, expected addr %0d data %0h",
                   i, wa_q[i], wd_q[i], i, exp_q[i]);
        mism++;
      end
    end
    check({nm, "_write_content"}, mism, 0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [7:0] pb;
    exp_q.delete();
    for (int i = 0; i < v.exp_cnt; i++) exp_q.push_back(8'(v.seed * (i + 1)));
    start_pkt(v.hdr, v.brss, 10'(v.pylen), 13'(v.bitlen), v.ce, v.cg);
    if (v.hdr) begin
      for (int k = 0; k < (v.brss ? 8 : 16); k++) send_bit(k[0]);
    end
    for (int k = 0; k < v.nbits; k++) begin
      pb = 8'(v.seed * (k / 8 + 1));
      send_bit(pb[k % 8]);
    end
    end_pkt();
    wait_done(200);
    check({nm, "_bytecnt"}, cap_cnt, v.exp_cnt);
    check({nm, "_trunc"}, cap_trunc, v.exp_trunc);
    check({nm, "_crcerr"}, cap_crc, v.exp_crc);
    check({nm, "_ovf"}, cap_ovf, 0);
    check_writes(nm);
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d4 [4];
    logic [7:0] b;
    //           hdr brss pylen bitlen nbits seed   ce cg cnt  trunc crc
    vecs[0] = '{1, 1,   5,    0,    56,   8'h11, 0, 1, 5,    0, 0};
    vecs[1] = '{1, 0,   1023, 0,    8200, 8'h07, 1, 1, 1021, 1, 0};
    vecs[2] = '{0, 0,   0,    19,   19,   8'h5b, 0, 0, 2,    0, 0};
    vecs[3] = '{1, 0,   3,    0,    40,   8'h9d, 1, 0, 3,    0, 1};
    vecs[4] = '{1, 1,   0,    0,    16,   8'h33, 0, 1, 0,    0, 0};
    vecs[5] = '{1, 1,   4,    0,    20,   8'h21, 0, 1, 2,    0, 0};
    vecs[6] = '{0, 1,   0,    7,    7,    8'h44, 0, 1, 0,    0, 0};

    rstz = 1'b0; dec_py_period = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    existpyheader = 1'b0; BRss = 1'b0; dec_pylenByte = '0; rxpybitlen = '0;
    crcencode = 1'b0; dec_crcgood = 1'b1; mem_ready = 1'b1;
    repeat (3) @(posedge clk_6M);
    @(negedge clk_6M);
    check("reset_state", {mem_we, mem_addr, mem_wdata, rxpy_done_p, rxpy_bytecnt,
                          rxpy_crcerr, rxpy_ovf, rxpy_trunc}, 0);
    @(posedge clk_6M); #1 rstz = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Overflow: buffer stalls for 20 bit periods over a 4-byte stream.
    d4 = '{8'h3C, 8'hC3, 8'h5A, 8'hA5};
    exp_q.delete(); exp_q.push_back(8'h3C); exp_q.push_back(8'h5A); exp_q.push_back(8'hA5);
    start_pkt(1, 1, 10'd4, 13'd0, 0, 1);
    for (int k = 0; k < 8; k++) send_bit(1'b1);
    #1 mem_ready = 1'b0;
    for (int k = 0; k < 48; k++) begin
      if (k == 20) #1 mem_ready = 1'b1;
      b = (k < 32) ? d4[k / 8] : 8'hFF;
      send_bit(b[k % 8]);
    end
    end_pkt();
    wait_done(200);
    check("ovf_flag", cap_ovf, 1);
    check("ovf_bytecnt", cap_cnt, 3);
    check_writes("ovf");

    // Done must wait for the pending write to drain.
    exp_q.delete(); exp_q.push_back(8'h6E);
    start_pkt(1, 1, 10'd1, 13'd0, 1, 1);
    #1 mem_ready = 1'b0;
    for (int k = 0; k < 8; k++) send_bit(1'b0);
    b = 8'h6E;
    for (int k = 0; k < 24; k++) send_bit(b[k % 8]);
    end_pkt();
    begin
      int early = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk_6M);
        if (rxpy_done_p) early++;
      end
      check("drain_no_early_done", early, 0);
      check("drain_we_held", mem_we, 1);
    end
    @(posedge clk_6M); #1 mem_ready = 1'b1;
    wait_done(50);
    check("drain_bytecnt", cap_cnt, 1);
    check("drain_crcerr", cap_crc, 0);
    check_writes("drain");

    // Asynchronous reset with a write pending.
    start_pkt(1, 1, 10'd3, 13'd0, 0, 1);
    #1 mem_ready = 1'b0;
    for (int k = 0; k < 20; k++) send_bit(1'b1);
    @(negedge clk_6M);
    check("rst_pre_we", mem_we, 1);
    #2 rstz = 1'b0;
    #1;
    check("rst_async_clear", {mem_we, mem_addr, mem_wdata, rxpy_done_p, rxpy_bytecnt,
                              rxpy_crcerr, rxpy_ovf, rxpy_trunc}, 0);
    dec_py_period = 1'b0; bit_valid = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk_6M);
    #1 rstz = 1'b1;
    repeat (2) @(posedge clk_6M);
    run_vec(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rxpy_byte_wr.md
Name: rxpy_byte_wr

Overview:
- Downstream of the RX payload bit processor. Consumes the serial decoded payload bit stream during the decode period.
- Strips the payload header (1 byte single-slot BR, 2 bytes otherwise) and packs the user data bits LSB-first into bytes.
- Writes each byte to the RX payload buffer SRAM through a one-entry holding register with a ready handshake.
- At end of packet, reports byte count, CRC status, overflow and truncation to the link controller.

Parameters:
- ADDR_W, 10, RX buffer byte address width.
- MAXBYTES, 1021, maximum payload bytes stored; excess bytes are dropped.

Ports:
- clk_6M  in  1  system clock 6 MHz
- rstz  in  1  async active-low reset
- dec_py_period  in  1  decode window from upstream; high while decoded bits are valid
- bit_valid  in  1  one-cycle strobe: bit_in valid this cycle (gated by upstream daten)
- bit_in  in  1  decoded, de-whitened payload bit
- existpyheader  in  1  payload carries a header
- BRss  in  1  basic-rate single-slot (1-byte header) when high
- dec_pylenByte  in  10  decoded payload length in bytes, from upstream
- rxpybitlen  in  13  payload bit length used when existpyheader=0
- crcencode  in  1  packet carries CRC16
- dec_crcgood  in  1  upstream CRC check result
- mem_ready  in  1  buffer accepts write this cycle
- mem_we  out  1  write request; held until mem_ready
- mem_addr  out  ADDR_W  byte address, starts at 0 per packet
- mem_wdata  out  8  byte data
- rxpy_done_p  out  1  one-cycle end-of-packet pulse
- rxpy_bytecnt  out  10  bytes actually written
- rxpy_crcerr  out  1  crcencode & !dec_crcgood, latched at done
- rxpy_ovf  out  1  byte lost because holding register still busy
- rxpy_trunc  out  1  length exceeded MAXBYTES

Behaviour:
- Reset values: all outputs 0, FSM IDLE, counters 0, holding register empty.
- FSM states IDLE, HDR, DATA, SKIP, DONE.
- IDLE: on rising edge of dec_py_period, clear bitcnt, addr, bytecnt, ovf, trunc. Go to HDR if existpyheader, else DATA with target = rxpybitlen[12:3] (low 3 bits ignored).
- HDR: count bit_valid strobes; header bits are discarded. After 8 (BRss=1) or 16 (BRss=0) bits, go to DATA.
- On the HDR->DATA transition cycle, latch target = min(dec_pylenByte, MAXBYTES); set rxpy_trunc if dec_pylenByte > MAXBYTES.
- Target 0 goes straight to SKIP.
- DATA: shift bit_in into byte shift register, LSB first; first data bit becomes bit0.
  - On the 8th bit, move the byte to the holding register.
  - Increment byte counter; on reaching target, go to SKIP.
- SKIP: ignore remaining bits (CRC16 and any bytes beyond MAXBYTES).
- Falling edge of dec_py_period in any state other than IDLE: go to DONE.
  - A partial byte (fewer than 8 bits) is discarded.
- DONE, one cycle:
  - Wait, if the holding register is still pending, until it drains; then pulse rxpy_done_p.
  - rxpy_bytecnt = bytes written.
  - rxpy_crcerr = crcencode & !dec_crcgood, sampled in the cycle dec_py_period falls.
  - Return to IDLE.
- Write handshake:
  - mem_we asserts the cycle after the byte completes.
  - mem_addr/mem_wdata are stable while mem_we=1.
  - Transfer occurs on mem_we & mem_ready; mem_we drops the next cycle unless a new byte is loaded the same cycle.
  - addr increments per transfer; no wrap (bounded by MAXBYTES < 2^ADDR_W).
- Overflow: a new byte completes while the holding register is occupied and not transferring that cycle.
  - The new byte is dropped; rxpy_ovf sets sticky until next packet start.
  - The byte is not counted in rxpy_bytecnt.
  - Completion and transfer in the same cycle is legal (no ovf).
- Outputs rxpy_bytecnt/crcerr/ovf/trunc hold their values until the next packet start.
- bit_valid outside dec_py_period is ignored.
- Rising edge of dec_py_period while not in IDLE (missed end): abort, restart the packet, no done pulse.
- Async reset mid-packet: everything cleared immediately; no pending write survives.

Decomposition:
- Shared package: FSM state encoding, HDR_BITS_BRSS=8, HDR_BITS_MS=16, default MAXBYTES.
- One natural sub-module: rxpy_wr_hold (one-entry holding register + mem_we/mem_ready handshake + address counter).

Test Plan:
- BRss=1, header len 5, 40 data bits 0x11,0x22,0x33,0x44,0x55 LSB-first + 16 CRC bits, mem_ready=1 -> 5 writes addr 0..4 with correct data, done pulse, bytecnt=5, crcerr=0.
- BRss=0, dec_pylenByte=1023, MAXBYTES=1021 -> 1021 writes, trunc=1, remaining bits ignored, bytecnt=1021.
- existpyheader=0, rxpybitlen=19 -> 2 bytes written, last 3 bits ignored, bytecnt=2.
- mem_ready held low for 20 bit periods during a 4-byte stream -> first byte held, ovf=1, dropped bytes uncounted, done delayed until drain.
- crcencode=1, dec_crcgood=0 at end -> crcerr=1 on done; next packet clears ovf/trunc at start.
- Assert rstz low mid-DATA with mem_we=1 -> all outputs 0 immediately; next packet starts at addr 0.
